// File: rtl/cond_flag_unit_pkg.sv
// Shared types and constants for the condition-flag unit: FSM states,
// ARM condition codes, the V-updating arithmetic op set and NZCV bit positions.
package cond_flag_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // One bit per data-processing op field: SUB,RSB,ADD,ADC,SBC,RSC,CMP,CMN.
    localparam logic [15:0] ARITH_OP_SET = 16'h0CFC;

    function automatic logic is_arith_op(input logic [3:0] op);
        return ARITH_OP_SET[op];
    endfunction

endpackage

// File: rtl/cond_flag_unit_cond_eval.sv
// Combinational ARM condition-code evaluator: pass is high when the
// condition field is satisfied by the supplied NZCV flags.
module cond_eval
    import cond_flag_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Architectural NZCV register fed by ALU results, plus a small FSM that
// checks each issued instruction's condition field against those flags.
module cond_flag_unit
    import cond_flag_unit_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_ALUout,
    input  logic        res_Cout,
    input  logic        res_Vout,
    input  logic [31:0] res_OPCODE,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [31:0] iss_OPCODE,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_exec,
    output logic [31:0] out_OPCODE,
    output logic [3:0]  NZCV
);

    state_e      state_q, state_d;
    logic [3:0]  nzcv_q, nzcv_d;
    logic [31:0] opc_q, opc_d;
    logic        exec_q, exec_d;
    logic        stall_q, stall_d;

    logic res_xfer;
    logic is_mul;
    logic is_s_dp;
    logic flag_write;
    logic hazard;
    logic accept_win;
    logic pass;
    logic unused_opc_bits;

    assign res_ready = 1'b1;
    assign res_xfer  = res_valid && res_ready;

    assign is_mul     = (res_OPCODE[7:4] == 4'b1001) && !res_OPCODE[25];
    assign is_s_dp    = (res_OPCODE[27:26] == 2'b00) && res_OPCODE[20];
    assign flag_write = res_xfer && is_s_dp;
    // A multiply-with-S also writes N/Z, so it must stall issue just like a flag-setting op.
    assign hazard     = flag_write;

    assign unused_opc_bits = ^{res_OPCODE[31:28], res_OPCODE[19:8], res_OPCODE[3:0]};

    always_comb begin
        nzcv_d = nzcv_q;
        if (flag_write) begin
            nzcv_d[FLAG_N] = res_ALUout[31];
            nzcv_d[FLAG_Z] = (res_ALUout == 32'd0);
            if (!is_mul) begin
                nzcv_d[FLAG_C] = res_Cout;
                if (is_arith_op(res_OPCODE[24:21])) begin
                    nzcv_d[FLAG_V] = res_Vout;
                end
            end
        end
    end

    cond_eval u_cond_eval (
        .cond (opc_q[31:28]),
        .nzcv (nzcv_q),
        .pass (pass)
    );

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        exec_d     = exec_q;
        accept_win = 1'b0;
        out_valid  = 1'b0;
        out_exec   = exec_q;
        case (state_q)
            ST_IDLE: begin
                accept_win = 1'b1;
            end
            ST_EVAL: begin
                out_valid = 1'b1;
                out_exec  = pass;
                exec_d    = pass;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    accept_win = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The stall is limited to one cycle: stall_q lets the waiting instruction through.
        iss_ready = accept_win && !(hazard && !stall_q);
        stall_d   = accept_win && iss_valid && hazard && !stall_q;

        if (iss_valid && iss_ready) begin
            state_d = ST_EVAL;
            opc_d   = iss_OPCODE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            nzcv_q  <= RESET_FLAGS;
            opc_q   <= 32'd0;
            exec_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            nzcv_q  <= nzcv_d;
            opc_q   <= opc_d;
            exec_q  <= exec_d;
            stall_q <= stall_d;
        end
    end

    assign out_OPCODE = opc_q;
    assign NZCV       = nzcv_q;

endmodule

// File: doc/cond_flag_unit.md
COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 SHALL have parameter RESET_FLAGS, default 4'b0000, meaning the NZCV value loaded on reset.
REQ-002 SHALL have port clk input 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-004 SHALL have port res_valid input 1: an ALU result is presented.
REQ-005 SHALL have port res_ready output 1: the unit accepts the result.
REQ-006 SHALL have port res_ALUout input 32: the ALU result.
REQ-007 SHALL have port res_Cout input 1: the ALU carry.
REQ-008 SHALL have port res_Vout input 1: the ALU overflow.
REQ-009 SHALL have port res_OPCODE input 32: the instruction that produced the result.
REQ-010 SHALL have port iss_valid input 1: the next instruction is presented for condition check.
REQ-011 SHALL have port iss_ready output 1: the instruction is accepted.
REQ-012 SHALL have port iss_OPCODE input 32: the next instruction.
REQ-013 SHALL have port out_valid output 1: a condition verdict is available.
REQ-014 SHALL have port out_ready input 1: downstream accepts the verdict.
REQ-015 SHALL have port out_exec output 1: the condition passed.
REQ-016 SHALL have port out_OPCODE output 32: the instruction carrying the verdict.
REQ-017 SHALL have port NZCV output 4: the architectural flags {N,Z,C,V}.

Function
REQ-018 Result transfer: occurs when res_valid && res_ready; res_ready SHALL be constant 1.
REQ-019 Flag-setting result: res_OPCODE[27:26]==2'b00, bit[20]==1, and not a multiply (bits[7:4]==4'b1001 with bits[25]==0 gives multiply).
REQ-020 On a flag-setting result the next edge SHALL load N=res_ALUout[31], Z=(res_ALUout==0), C=res_Cout.
REQ-021 V SHALL load res_Vout only for op field [24:21] in {0010,0011,0100,0101,0110,0111,1010,1011}; otherwise V SHALL hold.
REQ-022 A multiply with bit[20]==1 SHALL update N and Z only.
REQ-023 Results that do not set flags SHALL leave NZCV unchanged.
REQ-024 The FSM SHALL have states IDLE, EVAL and HOLD.
REQ-025 IDLE: iss_ready=1; on an issue transfer go to EVAL and latch iss_OPCODE.
REQ-026 Hazard: if a flag-setting result transfers in the same cycle as an issue request, iss_ready SHALL be 0 that cycle.
REQ-027 The hazard stall SHALL be exactly one cycle, so the instruction is evaluated against the updated flags.
REQ-028 EVAL: compute out_exec from the latched OPCODE[31:28] and the current NZCV; assert out_valid; go to HOLD.
REQ-029 Condition codes SHALL be: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, NV 0.
REQ-030 HOLD: out_valid, out_exec and out_OPCODE SHALL stay stable until out_ready.
REQ-031 On out_ready in HOLD: if iss_valid and no hazard, accept the new instruction and go to EVAL (back-to-back); otherwise go to IDLE.
REQ-032 Latency: issue transfer to out_valid SHALL be 1 cycle, or 2 cycles with the hazard stall.
REQ-033 Throughput SHALL be one verdict per 2 cycles.
REQ-034 iss_ready SHALL be 0 in EVAL.
REQ-035 A flag update during HOLD SHALL NOT alter the held out_exec.

Reset
REQ-036 On rst_n low: NZCV=RESET_FLAGS, state=IDLE, out_valid=0, out_exec=0, out_OPCODE=0.
REQ-037 On rst_n low, iss_ready SHALL be 1 after release.
REQ-038 Reset mid-transaction SHALL discard any latched instruction with no verdict emitted.

Structure
REQ-039 A shared package SHALL hold: the FSM state enum, condition-code constants (EQ..NV), the arithmetic-op set, and the flag index constants N=3, Z=2, C=1, V=0.
REQ-040 The combinational condition evaluator SHALL be sub-module cond_eval (inputs cond[3:0] and nzcv[3:0]; output pass).

Verification
REQ-041 Reset -> NZCV=0000, out_valid=0, iss_ready=1.
REQ-042 Result SUBS (res_OPCODE=0xE2500001), ALUout=0, Cout=1, Vout=0 -> NZCV=0110 next cycle; then issue BEQ (0x0A000000) -> out_exec=1, out_valid 1 cycle after transfer.
REQ-043 Flag-setting result and issue of BNE in the same cycle -> iss_ready=0 for one cycle, verdict uses the new flags (Z=1 -> out_exec=0).
REQ-044 ANDS (0xE2100000), ALUout=0x80000000, prior V=1 -> NZCV=1001 or 1011 per Cout, V held at 1.
REQ-045 out_ready held low for 5 cycles with a flag update mid-hold -> out_exec/out_OPCODE stable; after release, back-to-back issue reaches EVAL with no IDLE cycle.
REQ-046 Sweep all 16 conditions × 16 NZCV values -> out_exec matches the table in REQ-029; NV always 0.
